// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared selection width, source count and source index constants for the MU0 display path.
package display_pkg;

  localparam int SEL_W   = 3;
  localparam int NUM_SRC = 8;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SRC_ADDR  = 3'd0;
  localparam sel_t SRC_DIN   = 3'd1;
  localparam sel_t SRC_DOUT  = 3'd2;
  localparam sel_t SRC_PC    = 3'd3;
  localparam sel_t SRC_IR    = 3'd4;
  localparam sel_t SRC_ACC   = 3'd5;
  localparam sel_t SRC_D     = 3'd6;
  localparam sel_t SRC_SPARE = 3'd7;

  function automatic logic [15:0] src_word(input logic [16*NUM_SRC-1:0] v, input sel_t s);
    return v[{s, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/display_select_if.sv
// rtl/display_select_if.sv - button/switch inputs, datapath taps and display outputs; btn_prev exists under DISPLAY_SELECT_PREV_EN.
interface display_select_if;
  import display_pkg::*;

  logic                     btn_next;
  logic                     auto_en;
  logic [16*NUM_SRC-1:0]    values;
  sel_t                     sel;
  logic [15:0]              disp_value;
  logic                     sel_changed;

`ifdef DISPLAY_SELECT_PREV_EN
  logic                     btn_prev;

  modport master (output btn_next, btn_prev, auto_en, values,
                  input  sel, disp_value, sel_changed);
  modport slave  (input  btn_next, btn_prev, auto_en, values,
                  output sel, disp_value, sel_changed);
`else
  modport master (output btn_next, auto_en, values,
                  input  sel, disp_value, sel_changed);
  modport slave  (input  btn_next, auto_en, values,
                  output sel, disp_value, sel_changed);
`endif

endinterface

// File: rtl/display_select_button_debounce.sv
// rtl/display_select_button_debounce.sv - 2-flop synchroniser, stable-level debouncer and registered rising-edge press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 26
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             prev_q, prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any sample matching the stable level throws away the partial count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    prev_d  = stable_q;
    press_d = stable_q & ~prev_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/display_select.sv
// rtl/display_select.sv - steps the 7-segment source select on button presses or auto ticks; DISPLAY_SELECT_PREV_EN adds a step-back button.
module display_select
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_CYCLES     = 25000000,
  parameter int CNT_W           = 26
) (
  input  logic            Clk,
  input  logic            Reset,
  display_select_if.slave io
);

  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CYCLES - 1);

  logic             press_next;
  logic             press_prev;
  logic             tick;
  logic             restart;
  logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;
  sel_t             sel_q, sel_d;
  logic             sel_changed_q, sel_changed_d;
  logic [15:0]      disp_value_q, disp_value_d;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_next (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_raw (io.btn_next),
    .press   (press_next)
  );

`ifdef DISPLAY_SELECT_PREV_EN
  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_prev (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_raw (io.btn_prev),
    .press   (press_prev)
  );
`else
  assign press_prev = 1'b0;
`endif

  always_comb begin
    tick    = io.auto_en && (auto_cnt_q == AUTO_LAST);
    restart = press_next | press_prev;

    // A manual step buys a full period before the next automatic one.
    auto_cnt_d = auto_cnt_q + CNT_W'(1);
    if (!io.auto_en || restart || tick) begin
      auto_cnt_d = '0;
    end

    sel_d         = sel_q;
    sel_changed_d = 1'b0;
    if (press_prev && !press_next) begin
      sel_d         = sel_q - sel_t'(1);
      sel_changed_d = 1'b1;
    end else if (!press_prev && (press_next || tick)) begin
      sel_d         = sel_q + sel_t'(1);
      sel_changed_d = 1'b1;
    end

    disp_value_d = src_word(io.values, sel_d);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      auto_cnt_q    <= '0;
      sel_q         <= SRC_ADDR;
      sel_changed_q <= 1'b0;
      disp_value_q  <= 16'h0000;
    end else begin
      auto_cnt_q    <= auto_cnt_d;
      sel_q         <= sel_d;
      sel_changed_q <= sel_changed_d;
      disp_value_q  <= disp_value_d;
    end
  end

  assign io.sel         = sel_q;
  assign io.sel_changed = sel_changed_q;
  assign io.disp_value  = disp_value_q;

endmodule

// File: tb/tb_display_select.sv
// tb/tb_display_select.sv - directed and random stimulus for display_select checked against a behavioural model.
module tb_display_select;

  localparam int D = 4;
  localparam int A = 10;

  logic Clk;
  logic rst;
  int   total;
  int   bad;
  int   n;
  int   base;
  int   lat;
  int   cnt;

  display_select_if io ();

  display_select #(
    .DEBOUNCE_CYCLES (D),
    .AUTO_CYCLES     (A),
    .CNT_W           (8)
  ) dut (
    .Clk   (Clk),
    .Reset (rst),
    .io    (io)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  bit          m_s1[2];
  bit          m_s2[2];
  bit          m_stable[2];
  bit          m_rose[2];
  bit          m_press[2];
  bit          hist[2][$];
  logic [2:0]  m_sel;
  logic [15:0] m_disp;
  logic        m_chg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_k(input logic [127:0] v, input int k);
    return v[16*k +: 16];
  endfunction

  // Model: the stable level flips once the last D synchronised samples all
  // disagree with it; sel follows press/tick with the prescaler phase kept as
  // (edge - base) mod A.
  task automatic model_edge();
    bit b[2];
    bit pn, pp, tick, all_diff;
    b[0] = io.btn_next;
`ifdef DISPLAY_SELECT_PREV_EN
    b[1] = io.btn_prev;
`else
    b[1] = 1'b0;
`endif
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_stable[c] = 0; m_rose[c] = 0; m_press[c] = 0;
        hist[c].delete();
        repeat (D) hist[c].push_back(1'b0);
      end
      m_sel = 3'd0; m_disp = 16'h0; m_chg = 1'b0;
      base = n + 1;
    end else begin
      pn = m_press[0];
      pp = m_press[1];
      tick = io.auto_en && (((n - base) % A) == A - 1);
      if (!io.auto_en || pn || pp) base = n + 1;
      m_chg = 1'b0;
      if (pp && !pn) begin
        m_sel = m_sel - 3'd1; m_chg = 1'b1;
      end else if (!pp && (pn || tick)) begin
        m_sel = m_sel + 3'd1; m_chg = 1'b1;
      end
      m_disp = word_k(io.values, int'(m_sel));
      for (int c = 0; c < 2; c++) begin
        hist[c].push_back(m_s2[c]);
        while (hist[c].size() > D) void'(hist[c].pop_front());
        all_diff = 1'b1;
        for (int i = 0; i < hist[c].size(); i++)
          if (hist[c][i] == m_stable[c]) all_diff = 1'b0;
        m_press[c] = m_rose[c];
        m_rose[c] = 1'b0;
        if (all_diff) begin
          m_stable[c] = ~m_stable[c];
          m_rose[c] = m_stable[c];
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = b[c];
      end
    end
    n++;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge Clk);
    @(negedge Clk);
    chk("sel", io.sel, m_sel);
    chk("disp", io.disp_value, m_disp);
    chk("chg", io.sel_changed, m_chg);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_change(input int max, output int l);
    l = -1;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (io.sel_changed) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic count_changes(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      cycle();
      if (io.sel_changed) c++;
    end
  endtask

  task automatic clean_press();
    io.btn_next = 1'b1;
    repeat (6) cycle();
    io.btn_next = 1'b0;
    repeat (8) cycle();
  endtask

  initial begin
    total = 0; bad = 0; n = 0; base = 0;
    rst = 1'b1;
    io.btn_next = 1'b0;
    io.auto_en = 1'b0;
    io.values = '0;
`ifdef DISPLAY_SELECT_PREV_EN
    io.btn_prev = 1'b0;
`endif
    for (int k = 0; k < 8; k++) io.values[16*k +: 16] = 16'h1000 + 16'(k);

    do_reset();
    chk("rst_sel", io.sel, 0);
    chk("rst_disp", io.disp_value, 0);
    chk("rst_chg", io.sel_changed, 0);

    // Held button: one step, fixed latency.
    io.btn_next = 1'b1;
    wait_change(20, lat);
    chk("press_lat", lat, 2 + D + 2);
    chk("press_sel", io.sel, 1);
    chk("press_disp", io.disp_value, 16'h1001);
    count_changes(12, cnt);
    chk("hold_extra", cnt, 0);
    io.btn_next = 1'b0;
    repeat (10) cycle();

    // Bounce shorter than the debounce window.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      io.btn_next = ((i / 2) % 2 == 0);
      cycle();
      if (io.sel_changed) cnt++;
    end
    io.btn_next = 1'b0;
    count_changes(12, cnt);
    chk("bounce_chg", cnt, 0);
    chk("bounce_sel", io.sel, 0);

    // Eight clean presses walk all sources and wrap.
    for (int k = 1; k <= 8; k++) begin
      clean_press();
      chk("seq_sel", io.sel, k % 8);
      chk("seq_disp", io.disp_value, 16'h1000 + 16'(k % 8));
    end

    // Auto mode period.
    do_reset();
    io.auto_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_change(15, lat);
      chk("auto_period", lat, A);
    end
    chk("auto_sel", io.sel, 5);

    // Press landing on the same edge as a tick.
    do_reset();
    io.auto_en = 1'b1;
    cycle();
    cycle();
    io.btn_next = 1'b1;
    repeat (7) cycle();
    chk("coin_pre", io.sel, 0);
    cycle();
    chk("coin_sel", io.sel, 1);
    repeat (9) cycle();
    chk("coin_gap", io.sel, 1);
    cycle();
    chk("coin_next", io.sel, 2);
    io.btn_next = 1'b0;
    io.auto_en = 1'b0;
    repeat (10) cycle();

    // Reset during a debounce count.
    do_reset();
    io.btn_next = 1'b1;
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_sel", io.sel, 0);
    wait_change(20, lat);
    chk("rst_deb_lat", lat, 2 + D + 2);
    io.btn_next = 1'b0;
    repeat (10) cycle();

    // Reset during an auto count.
    io.auto_en = 1'b1;
    do_reset();
    repeat (6) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_auto_sel", io.sel, 0);
    chk("rst_auto_disp", io.disp_value, 0);
    wait_change(30, lat);
    chk("rst_auto_lat", lat, A);
    io.auto_en = 1'b0;

`ifdef DISPLAY_SELECT_PREV_EN
    do_reset();
    io.btn_prev = 1'b1;
    repeat (6) cycle();
    io.btn_prev = 1'b0;
    repeat (8) cycle();
    chk("prev_wrap", io.sel, 7);
    io.btn_next = 1'b1;
    io.btn_prev = 1'b1;
    count_changes(20, cnt);
    chk("cancel_chg", cnt, 0);
    chk("cancel_sel", io.sel, 7);
    io.btn_next = 1'b0;
    io.btn_prev = 1'b0;
    repeat (10) cycle();
`endif

    // Random buttons, auto switch, datapath values and rare resets.
    begin
      int hold_n, hold_p;
      hold_n = 0;
      hold_p = 0;
      for (int i = 0; i < 800; i++) begin
        if (hold_n == 0) begin
          io.btn_next = 1'($urandom_range(0, 1));
          hold_n = $urandom_range(1, 9);
        end
        hold_n--;
`ifdef DISPLAY_SELECT_PREV_EN
        if (hold_p == 0) begin
          io.btn_prev = 1'($urandom_range(0, 1));
          hold_p = $urandom_range(1, 9);
        end
        hold_p--;
`endif
        if (i % 40 == 0) io.auto_en = 1'($urandom_range(0, 1));
        for (int k = 0; k < 8; k++) io.values[16*k +: 16] = 16'($urandom);
        rst = ($urandom_range(0, 199) == 0);
        cycle();
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
